// File: rtl/gpio_apb_arbiter_if.sv
// ---------------------------------------------------------------------------
// gpio_apb_arbiter_if
//
// Purpose:
//   Groups the two requester ports and the GPIO slave's APB pins that connect
//   to gpio_apb_arbiter into one bundle.
//
// Parameters:
//   OFS_W  width of the requester register byte offset
//
// Signals:
//   reqN_valid  request pending on port N            (requester -> arbiter)
//   reqN_ready  request accepted this cycle          (arbiter -> requester)
//   reqN_write  1 = write, 0 = read                  (requester -> arbiter)
//   reqN_ofs    register byte offset                 (requester -> arbiter)
//   reqN_wdata  write data                           (requester -> arbiter)
//   rspN_valid  one-cycle completion pulse           (arbiter -> requester)
//   rspN_rdata  read data, valid with rspN_valid     (arbiter -> requester)
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA             (arbiter -> GPIO slave)
//   PRDATA      read data                            (GPIO slave -> arbiter)
//
// Modports:
//   master  the arbiter's view (it masters the APB side)
//   slave   the environment's view (requesters plus GPIO slave)
// ---------------------------------------------------------------------------
interface gpio_apb_arbiter_if #(
  parameter int OFS_W = 4
) ();

  logic             req0_valid;
  logic             req0_ready;
  logic             req0_write;
  logic [OFS_W-1:0] req0_ofs;
  logic [31:0]      req0_wdata;
  logic             rsp0_valid;
  logic [31:0]      rsp0_rdata;

  logic             req1_valid;
  logic             req1_ready;
  logic             req1_write;
  logic [OFS_W-1:0] req1_ofs;
  logic [31:0]      req1_wdata;
  logic             rsp1_valid;
  logic [31:0]      rsp1_rdata;

  logic             PSEL;
  logic             PENABLE;
  logic             PWRITE;
  logic [31:0]      PADDR;
  logic [31:0]      PWDATA;
  logic [31:0]      PRDATA;

  modport master (
    input  req0_valid, req0_write, req0_ofs, req0_wdata,
    input  req1_valid, req1_write, req1_ofs, req1_wdata,
    input  PRDATA,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req0_valid, req0_write, req0_ofs, req0_wdata,
    output req1_valid, req1_write, req1_ofs, req1_wdata,
    output PRDATA,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/gpio_apb_arbiter.sv
// ---------------------------------------------------------------------------
// gpio_apb_arbiter
//
// Purpose:
//   Shares the GPIO peripheral's APB slave between two requesters (port 0:
//   core-side register access, port 1: pattern/sampling engine). Requests are
//   granted round-robin and each accepted request runs as a two-phase APB
//   transfer (SETUP, ACCESS), followed by a one-cycle response pulse on the
//   granted port in the first IDLE cycle.
//
// Parameters:
//   BASE_ADDR  GPIO slave base address, OR'ed into PADDR
//   OFS_W      width of the requester byte offset
//
// Ports:
//   PCLK    clock, all logic on the rising edge
//   PRESET  synchronous active-high reset
//   bus     gpio_apb_arbiter_if.master: requester handshakes, responses and
//           the APB pins toward the GPIO slave
// ---------------------------------------------------------------------------
module gpio_apb_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          OFS_W     = 4
) (
  input  logic               PCLK,
  input  logic               PRESET,
  gpio_apb_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e      state_q, state_d;

  // Port that won the previous grant; it loses the next tie.
  logic        lastGrant_q, lastGrant_d;
  // Port that owns the transfer currently in flight.
  logic        grantPort_q, grantPort_d;

  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;

  logic        rsp0Valid_q, rsp0Valid_d;
  logic        rsp1Valid_q, rsp1Valid_d;
  logic [31:0] rsp0Rdata_q, rsp0Rdata_d;
  logic [31:0] rsp1Rdata_q, rsp1Rdata_d;

  logic        grant;
  logic        ready0;
  logic        ready1;
  logic [31:0] accessRdata;

  // Register addresses are word aligned: the two low offset bits are
  // discarded so a sub-word offset still hits the containing register.
  function automatic logic [31:0] alignedAddr(input logic [OFS_W-1:0] ofs);
    return BASE_ADDR | (32'(ofs) & ~32'h0000_0003);
  endfunction

  // Round-robin grant. A lone requester always wins; on a tie the port that
  // did not win last time goes next, which makes grants alternate 0,1,0,1
  // while both ports stay valid.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && !bus.req1_valid) begin
      grant = 1'b0;
    end else if (bus.req1_valid && !bus.req0_valid) begin
      grant = 1'b1;
    end else if (bus.req0_valid && bus.req1_valid) begin
      grant = ~lastGrant_q;
    end
  end

  assign ready0 = (state_q == IDLE) && bus.req0_valid && (grant == 1'b0);
  assign ready1 = (state_q == IDLE) && bus.req1_valid && (grant == 1'b1);

  // Read data returned to the requester: a write completes with zero.
  assign accessRdata = pwrite_q ? 32'h0000_0000 : bus.PRDATA;

  // Next-state and next-output logic. The APB pins are computed one cycle
  // ahead so that they come straight from flops. The accepted request's
  // direction, address and write data are captured directly into the PWRITE,
  // PADDR and PWDATA registers at the acceptance edge, which is also what
  // holds them stable through ACCESS and afterwards in IDLE.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    grantPort_d = grantPort_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp0Valid_d = 1'b0;
    rsp1Valid_d = 1'b0;
    rsp0Rdata_d = rsp0Rdata_q;
    rsp1Rdata_d = rsp1Rdata_q;

    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (ready0 || ready1) begin
          state_d     = SETUP;
          grantPort_d = grant;
          lastGrant_d = grant;
          psel_d      = 1'b1;
          if (grant) begin
            pwrite_d = bus.req1_write;
            paddr_d  = alignedAddr(bus.req1_ofs);
            pwdata_d = bus.req1_write ? bus.req1_wdata : 32'h0000_0000;
          end else begin
            pwrite_d = bus.req0_write;
            paddr_d  = alignedAddr(bus.req0_ofs);
            pwdata_d = bus.req0_write ? bus.req0_wdata : 32'h0000_0000;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end

      ACCESS: begin
        // No PREADY on this slave, so ACCESS always closes after one cycle.
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (grantPort_q) begin
          rsp1Valid_d = 1'b1;
          rsp1Rdata_d = accessRdata;
        end else begin
          rsp0Valid_d = 1'b1;
          rsp0Rdata_d = accessRdata;
        end
      end

      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset abandons any transfer in flight:
  // nothing is signalled back to the requester and the bus is idle on the
  // following cycle. lastGrant resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      grantPort_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 32'h0000_0000;
      pwdata_q    <= 32'h0000_0000;
      rsp0Valid_q <= 1'b0;
      rsp1Valid_q <= 1'b0;
      rsp0Rdata_q <= 32'h0000_0000;
      rsp1Rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      grantPort_q <= grantPort_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp0Valid_q <= rsp0Valid_d;
      rsp1Valid_q <= rsp1Valid_d;
      rsp0Rdata_q <= rsp0Rdata_d;
      rsp1Rdata_q <= rsp1Rdata_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp0_valid = rsp0Valid_q;
  assign bus.rsp1_valid = rsp1Valid_q;
  assign bus.rsp0_rdata = rsp0Rdata_q;
  assign bus.rsp1_rdata = rsp1Rdata_q;
  assign bus.PSEL       = psel_q;
  assign bus.PENABLE    = penable_q;
  assign bus.PWRITE     = pwrite_q;
  assign bus.PADDR      = paddr_q;
  assign bus.PWDATA     = pwdata_q;

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gpio_apb_arbiter
//
// Purpose:
//   Directed self-checking bench for gpio_apb_arbiter. Drives both requester
//   ports and the slave's PRDATA through the interface and compares the APB
//   pins, handshakes and responses against hand-computed values.
// ---------------------------------------------------------------------------
module tb_gpio_apb_arbiter;

  localparam int          OFS_W = 4;
  localparam logic [31:0] BASE  = 32'h4000_0000;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;

  int checks = 0;
  int errors = 0;

  gpio_apb_arbiter_if #(.OFS_W(OFS_W)) bus ();

  gpio_apb_arbiter #(
    .BASE_ADDR(BASE),
    .OFS_W    (OFS_W)
  ) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  // Free-running clock, 10 time-unit period.
  always #5 PCLK = ~PCLK;

  // Absolute time limit so the run always ends even if the design locks up.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge, where outputs are
  // stable and new inputs can be driven.
  task automatic nextCycle();
    @(posedge PCLK);
    #1;
  endtask

  // Drive one requester port.
  task automatic applyStimulus(input int port, input logic valid, input logic write,
                               input logic [OFS_W-1:0] ofs, input logic [31:0] wdata);
    if (port == 0) begin
      bus.req0_valid = valid;
      bus.req0_write = write;
      bus.req0_ofs   = ofs;
      bus.req0_wdata = wdata;
    end else begin
      bus.req1_valid = valid;
      bus.req1_write = write;
      bus.req1_ofs   = ofs;
      bus.req1_wdata = wdata;
    end
  endtask

  // Word-wide comparison.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Single-bit comparison.
  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(0, 1'b0, 1'b0, '0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, '0, 32'h0);
    bus.PRDATA = 32'h0;

    // Reset values.
    PRESET = 1'b1;
    nextCycle();
    nextCycle();
    checkFlag  ("rst_psel",    bus.PSEL,       1'b0);
    checkFlag  ("rst_penable", bus.PENABLE,    1'b0);
    checkFlag  ("rst_pwrite",  bus.PWRITE,     1'b0);
    checkOutput("rst_paddr",   bus.PADDR,      32'h0);
    checkOutput("rst_pwdata",  bus.PWDATA,     32'h0);
    checkFlag  ("rst_rsp0v",   bus.rsp0_valid, 1'b0);
    checkFlag  ("rst_rsp1v",   bus.rsp1_valid, 1'b0);
    checkOutput("rst_rsp0d",   bus.rsp0_rdata, 32'h0);
    checkOutput("rst_rsp1d",   bus.rsp1_rdata, 32'h0);
    PRESET = 1'b0;

    // Port 0 write, ofs 4, data A5A5.
    applyStimulus(0, 1'b1, 1'b1, 4'h4, 32'h0000_A5A5);
    #1;
    checkFlag("wr0_ready0", bus.req0_ready, 1'b1);
    checkFlag("wr0_ready1", bus.req1_ready, 1'b0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, '0, 32'h0);
    checkFlag  ("wr0_setup_psel",    bus.PSEL,    1'b1);
    checkFlag  ("wr0_setup_penable", bus.PENABLE, 1'b0);
    checkFlag  ("wr0_setup_pwrite",  bus.PWRITE,  1'b1);
    checkOutput("wr0_setup_paddr",   bus.PADDR,   32'h4000_0004);
    checkOutput("wr0_setup_pwdata",  bus.PWDATA,  32'h0000_A5A5);
    nextCycle();
    checkFlag  ("wr0_access_psel",    bus.PSEL,    1'b1);
    checkFlag  ("wr0_access_penable", bus.PENABLE, 1'b1);
    checkOutput("wr0_access_paddr",   bus.PADDR,   32'h4000_0004);
    checkOutput("wr0_access_pwdata",  bus.PWDATA,  32'h0000_A5A5);
    nextCycle();
    checkFlag  ("wr0_rsp0v",     bus.rsp0_valid, 1'b1);
    checkOutput("wr0_rsp0d",     bus.rsp0_rdata, 32'h0);
    checkFlag  ("wr0_rsp1v",     bus.rsp1_valid, 1'b0);
    checkFlag  ("wr0_idle_psel", bus.PSEL,       1'b0);
    checkFlag  ("wr0_idle_pen",  bus.PENABLE,    1'b0);
    nextCycle();
    checkFlag  ("wr0_rsp0v_drop", bus.rsp0_valid, 1'b0);
    checkOutput("wr0_paddr_hold", bus.PADDR,      32'h4000_0004);

    // Port 1 read, ofs 0, slave returns 0xFF.
    applyStimulus(1, 1'b1, 1'b0, 4'h0, 32'hFFFF_FFFF);
    #1;
    checkFlag("rd1_ready1", bus.req1_ready, 1'b1);
    checkFlag("rd1_ready0", bus.req0_ready, 1'b0);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, '0, 32'h0);
    checkFlag  ("rd1_setup_pwrite", bus.PWRITE, 1'b0);
    checkOutput("rd1_setup_paddr",  bus.PADDR,  32'h4000_0000);
    checkOutput("rd1_setup_pwdata", bus.PWDATA, 32'h0);
    bus.PRDATA = 32'h0000_00FF;
    nextCycle();
    checkFlag("rd1_access_penable", bus.PENABLE, 1'b1);
    nextCycle();
    bus.PRDATA = 32'h0;
    checkFlag  ("rd1_rsp1v", bus.rsp1_valid, 1'b1);
    checkOutput("rd1_rsp1d", bus.rsp1_rdata, 32'h0000_00FF);
    checkFlag  ("rd1_rsp0v", bus.rsp0_valid, 1'b0);
    checkOutput("rd1_rsp0d", bus.rsp0_rdata, 32'h0);

    // Offset alignment: ofs 7 read, then back-to-back ofs C write.
    applyStimulus(0, 1'b1, 1'b0, 4'h7, 32'h0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, '0, 32'h0);
    checkOutput("ofs7_paddr", bus.PADDR, 32'h4000_0004);
    bus.PRDATA = 32'h1234_5678;
    nextCycle();
    nextCycle();
    checkFlag  ("ofs7_rsp0v", bus.rsp0_valid, 1'b1);
    checkOutput("ofs7_rsp0d", bus.rsp0_rdata, 32'h1234_5678);
    applyStimulus(0, 1'b1, 1'b1, 4'hC, 32'hDEAD_BEEF);
    #1;
    checkFlag("ofsC_b2b_ready0", bus.req0_ready, 1'b1);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, '0, 32'h0);
    checkOutput("ofsC_paddr",  bus.PADDR,  32'h4000_000C);
    checkOutput("ofsC_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
    bus.PRDATA = 32'h55AA_55AA;
    nextCycle();
    nextCycle();
    checkFlag  ("ofsC_rsp0v", bus.rsp0_valid, 1'b1);
    checkOutput("ofsC_rsp0d", bus.rsp0_rdata, 32'h0);
    checkOutput("ofsC_rsp1d", bus.rsp1_rdata, 32'h0000_00FF);
    bus.PRDATA = 32'h0;

    // Fairness from reset: both ports valid for four transfers.
    PRESET = 1'b1;
    nextCycle();
    PRESET = 1'b0;
    checkOutput("rst2_rsp0d", bus.rsp0_rdata, 32'h0);
    applyStimulus(0, 1'b1, 1'b1, 4'h8, 32'h1111_1111);
    applyStimulus(1, 1'b1, 1'b1, 4'hC, 32'h2222_2222);
    for (int i = 0; i < 12; i++) begin
      #1;
      checkFlag($sformatf("rr_ready0_c%0d", i), bus.req0_ready, (i % 6) == 0);
      checkFlag($sformatf("rr_ready1_c%0d", i), bus.req1_ready, (i % 6) == 3);
      checkFlag($sformatf("rr_both_c%0d", i), bus.req0_ready & bus.req1_ready, 1'b0);
      checkFlag($sformatf("rr_rsp0v_c%0d", i), bus.rsp0_valid, (i == 3) || (i == 9));
      checkFlag($sformatf("rr_rsp1v_c%0d", i), bus.rsp1_valid, i == 6);
      if ((i % 3) == 1) begin
        checkOutput($sformatf("rr_paddr_c%0d", i), bus.PADDR,
                    ((i % 6) == 1) ? 32'h4000_0008 : 32'h4000_000C);
      end
      nextCycle();
    end
    #1;
    checkFlag("rr_rsp1v_c12", bus.rsp1_valid, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, '0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, '0, 32'h0);
    nextCycle();

    // Reset during ACCESS of a port 0 read.
    applyStimulus(0, 1'b1, 1'b0, 4'h8, 32'h0);
    #1;
    checkFlag("rstx_ready0", bus.req0_ready, 1'b1);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, '0, 32'h0);
    nextCycle();
    checkFlag("rstx_access_pen", bus.PENABLE, 1'b1);
    bus.PRDATA = 32'hAAAA_AAAA;
    PRESET = 1'b1;
    nextCycle();
    PRESET = 1'b0;
    bus.PRDATA = 32'h0;
    checkFlag  ("rstx_psel",  bus.PSEL,       1'b0);
    checkFlag  ("rstx_pen",   bus.PENABLE,    1'b0);
    checkFlag  ("rstx_rsp0v", bus.rsp0_valid, 1'b0);
    checkOutput("rstx_rsp0d", bus.rsp0_rdata, 32'h0);
    nextCycle();
    checkFlag("rstx_rsp0v_late", bus.rsp0_valid, 1'b0);
    checkFlag("rstx_psel_late",  bus.PSEL,       1'b0);

    // Contention after reset: port 0 first, port 1 held pending.
    applyStimulus(0, 1'b1, 1'b1, 4'h4, 32'h0000_0F0F);
    applyStimulus(1, 1'b1, 1'b0, 4'h0, 32'h0);
    #1;
    checkFlag("post_ready0", bus.req0_ready, 1'b1);
    checkFlag("post_ready1", bus.req1_ready, 1'b0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, '0, 32'h0);
    checkFlag  ("hold1_setup_ready1", bus.req1_ready, 1'b0);
    checkOutput("hold1_pwdata",       bus.PWDATA,     32'h0000_0F0F);
    nextCycle();
    checkFlag("hold1_access_ready1", bus.req1_ready, 1'b0);
    nextCycle();
    checkFlag("hold1_rsp0v",  bus.rsp0_valid, 1'b1);
    checkFlag("hold1_ready1", bus.req1_ready, 1'b1);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, '0, 32'h0);
    applyStimulus(0, 1'b1, 1'b1, 4'hC, 32'h0000_3333);
    #1;
    checkFlag  ("hold0_setup_ready0", bus.req0_ready, 1'b0);
    checkFlag  ("hold0_pwrite",       bus.PWRITE,     1'b0);
    checkOutput("hold0_paddr",        bus.PADDR,      32'h4000_0000);
    nextCycle();
    bus.PRDATA = 32'h0000_0077;
    checkFlag("hold0_access_ready0", bus.req0_ready, 1'b0);
    nextCycle();
    bus.PRDATA = 32'h0;
    checkFlag  ("hold0_rsp1v",  bus.rsp1_valid, 1'b1);
    checkOutput("hold0_rsp1d",  bus.rsp1_rdata, 32'h0000_0077);
    checkFlag  ("hold0_ready0", bus.req0_ready, 1'b1);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, '0, 32'h0);
    checkOutput("hold0_setup_paddr",  bus.PADDR,  32'h4000_000C);
    checkOutput("hold0_setup_pwdata", bus.PWDATA, 32'h0000_3333);
    nextCycle();
    nextCycle();
    checkFlag("hold0_rsp0v", bus.rsp0_valid, 1'b1);
    nextCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_apb_arbiter.md
Name: gpio_apb_arbiter

Overview:
- Two-port APB master that shares the GPIO peripheral's APB slave interface between two requesters: port 0 (core-side register access) and port 1 (autonomous pattern/sampling engine).
- Arbitrates round-robin, sequences each accepted request as a standard two-phase APB transfer (SETUP then ACCESS), and returns a one-cycle response with read data.
- Sits between the requesters and the GPIO slave's PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA pins.

Parameters:
- BASE_ADDR, 32'h4000_0000, GPIO slave base address; OR'ed into PADDR.
- OFS_W, 4, width of requester register offset (byte offset within GPIO window).

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- req0_valid  in  1  port 0 request pending.
- req0_ready  out  1  port 0 request accepted this cycle (valid & ready).
- req0_write  in  1  1 = write, 0 = read.
- req0_ofs  in  OFS_W  register byte offset.
- req0_wdata  in  32  write data.
- rsp0_valid  out  1  one-cycle pulse: port 0 transfer complete.
- rsp0_rdata  out  32  read data, valid with rsp0_valid.
- req1_valid, req1_ready, req1_write, req1_ofs, req1_wdata, rsp1_valid, rsp1_rdata: same as port 0, for port 1.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data from slave.

Behaviour:
- Reset (PRESET=1 at a rising edge):
  - state=IDLE.
  - PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0.
  - rsp*_valid=0, rsp*_rdata=0.
  - last_grant=1, so port 0 wins the first contention.
- Reset mid-transfer: the transfer is abandoned, no response is issued, and PSEL/PENABLE are 0 in the cycle after the reset edge.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Grant selection:
    - Only one valid: grant = that port.
    - Both valid: grant = port != last_grant.
    - Neither valid: stay in IDLE.
  - reqN_ready = (state==IDLE) & reqN_valid & (grant==N). Combinational; at most one ready is high per cycle.
  - On acceptance:
    - Latch write, ofs, wdata and the granted port id.
    - last_grant <= granted port.
    - Next state SETUP.
- SETUP (1 cycle):
  - PSEL=1, PENABLE=0.
  - PWRITE = latched write.
  - PADDR = BASE_ADDR | {ofs[OFS_W-1:2], 2'b00}; low two bits are always 0.
  - PWDATA = latched wdata for writes, 0 for reads.
  - Next state ACCESS.
- ACCESS (1 cycle):
  - PSEL=1, PENABLE=1; PADDR, PWRITE and PWDATA are held unchanged.
  - The slave has no PREADY, so ACCESS is always exactly one cycle.
  - At the closing edge: if read, rsp<granted>_rdata <= PRDATA; if write, rdata <= 0.
  - At the closing edge: rsp<granted>_valid <= 1.
  - Next state IDLE.
- All APB outputs are registered and driven glitch-free. PSEL/PENABLE drop to 0 in IDLE; PADDR/PWDATA hold their last values.
- rspN_valid is high for exactly one cycle: the first IDLE cycle after ACCESS. rspN_rdata holds until the next response on that port.
- Latency and throughput:
  - Acceptance edge T: SETUP in T+1, ACCESS in T+2, rsp_valid in T+3.
  - A new request may be accepted in that same T+3 cycle.
  - Sustained throughput is one transfer per 3 cycles.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1…. No port waits more than one other transfer.
- Request inputs are sampled only on the acceptance edge; changes while not ready are ignored.
- The non-granted port's ready stays 0; its request stays pending (valid must be held by the requester).

Test Plan:
- Reset, then port0 write ofs=4'h4, wdata=32'h0000_A5A5 →
  - T+1: PSEL=1, PENABLE=0, PWRITE=1, PADDR=32'h4000_0004, PWDATA=32'h0000_A5A5.
  - T+2: PENABLE=1.
  - T+3: rsp0_valid=1, rsp0_rdata=0.
- Port1 read ofs=4'h0 with slave PRDATA=32'h0000_00FF during ACCESS → T+3: rsp1_valid=1, rsp1_rdata=32'h0000_00FF; rsp0_valid stays 0.
- Both ports valid from reset for 4 transfers → grant order 0,1,0,1; acceptances 3 cycles apart; req ready never high on both ports in one cycle.
- Port0 ofs=4'h7 → PADDR=32'h4000_0004; ofs=4'hC → PADDR=32'h4000_000C.
- PRESET asserted during ACCESS of a port0 read → next cycle PSEL=0, PENABLE=0, no rsp0_valid pulse; next contention grants port 0 first.
- Port0 valid held during an active port1 transfer → req0_ready=0 until IDLE, then accepted at the first IDLE cycle (T+3 of the port1 transfer).
